// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first unsigned subtractor computing A - B - Bin over WIDTH cycles
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a subtraction (honoured in IDLE or DONE)
//   A, B, Bin  minuend, subtrahend, borrow-in (captured at start)
//   busy       high while bits are being processed
//   done       one-cycle pulse when Diff/Bout hold a new result
//   Diff, Bout registered result and borrow-out
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic [IW-1:0] idx;
  logic br, d, br_n, last;
  assign d    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_n = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last = idx == IW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    if (state == RUN) state_n = last ? DONE : RUN;
    else state_n = start ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // operands shift right so bit 0 is always the current bit; the result
  // shifts in at the MSB so it lands in place after WIDTH steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      idx  <= '0;
      br   <= 1'b0;
      Diff <= '0;
      Bout <= 1'b0;
    end else if (state != RUN && start) begin
      a_sh <= A;
      b_sh <= B;
      br   <= Bin;
      idx  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_n;
      acc  <= {d, acc[WIDTH-1:1]};
      idx  <= idx + IW'(1);
      if (last) begin
        Diff <= {d, acc[WIDTH-1:1]};
        Bout <= br_n;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven and directed checks of serial_subtractor at WIDTH=4
module tb_serial_subtractor;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, Bin = 0;
  logic [3:0] A = 0, B = 0;
  logic busy, done, Bout;
  logic [3:0] Diff;
  int errors = 0, checks = 0;
  logic [3:0] prev_diff = 0;
  logic prev_bout = 0;
  vec_t vecs[10];
  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                    input logic [3:0] ed, input logic eb, input string name, input bit repulse);
    int lat, nb;
    lat = 0;
    nb = 0;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
      if (busy) nb++;
      if (k == 2) begin
        chk({name, " hold diff"}, Diff, prev_diff);
        chk({name, " hold bout"}, Bout, prev_bout);
        if (repulse) begin
          start = 1;
          A = 4'b1111;
        end
      end
      if (k == 3) start = 0;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({name, " latency"}, lat, 5);
    chk({name, " busy cycles"}, nb, 4);
    chk({name, " diff"}, Diff, ed);
    chk({name, " bout"}, Bout, eb);
    @(negedge clk);
    chk({name, " single done"}, done, 0);
    prev_diff = ed;
    prev_bout = eb;
  endtask
  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[1] = '{4'b0001, 4'b0001, 1'b1, 4'b1111, 1'b1};
    vecs[2] = '{4'b1010, 4'b0010, 1'b0, 4'b1000, 1'b0};
    vecs[3] = '{4'b0010, 4'b1010, 1'b0, 4'b1000, 1'b1};
    vecs[4] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1};
    vecs[5] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0};
    vecs[6] = '{4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0};
    vecs[7] = '{4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0};
    vecs[8] = '{4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b0};
    vecs[9] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1};
    #3;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", Diff, 0);
    chk("reset bout", Bout, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, $sformatf("vec%0d", i), 0);
    op(4'b1010, 4'b0010, 1'b0, 4'b1000, 1'b0, "repulse", 1);
    @(negedge clk);
    A = 4'b1010; B = 4'b0010; Bin = 0; start = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("held done k%0d", k), done, (k % 5 == 0));
      chk($sformatf("held busy k%0d", k), busy, (k % 5 != 0));
      if (k % 5 == 0) begin
        chk($sformatf("held diff k%0d", k), Diff, 4'b1000);
        chk($sformatf("held bout k%0d", k), Bout, 0);
      end
    end
    start = 0;
    @(negedge clk);
    chk("held stop", busy | done, 0);
    prev_diff = 4'b1000;
    prev_bout = 0;
    @(negedge clk);
    A = 4'b1111; B = 4'b0000; Bin = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("pre-reset busy", busy, 1);
    rst_n = 0;
    #1;
    chk("rst run busy", busy, 0);
    chk("rst run done", done, 0);
    chk("rst run diff", Diff, 0);
    chk("rst run bout", Bout, 0);
    #2 rst_n = 1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      chk("no done after reset", seen, 0);
    end
    chk("post reset diff", Diff, 0);
    prev_diff = 0;
    prev_bout = 0;
    op(4'b0111, 4'b0011, 1'b0, 4'b0100, 1'b0, "fresh", 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, giving the operand and difference width in bits; legal range 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on rising clk.
REQ-005 The block SHALL have ports A and B, input, WIDTH bits each: minuend and subtrahend, unsigned.
REQ-006 The block SHALL have port Bin, input, 1 bit: borrow-in.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port Diff, output, WIDTH bits: the result, equal to (A - B - Bin) mod 2^WIDTH.
REQ-010 The block SHALL have port Bout, output, 1 bit: borrow-out, high when A < B + Bin.

Function
REQ-011 The block SHALL implement a three-state machine with states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL capture A, B and Bin into internal registers, clear the bit index to 0, and enter RUN.
REQ-013 In RUN, the block SHALL process one bit per cycle, LSB first:
- d = a ^ b ^ br
- br_next = (~a & b) | (~(a ^ b) & br)
- br is initialised from Bin at capture.
REQ-014 After the edge that processes bit WIDTH-1, the block SHALL enter DONE.
REQ-015 At that same edge, the block SHALL load Diff with the assembled result and Bout with the final borrow.
REQ-016 Latency SHALL be fixed: start is sampled at edge N, and done is high for exactly the cycle following edge N+WIDTH.
REQ-017 busy SHALL equal 1 exactly while the state is RUN; done SHALL equal 1 exactly while the state is DONE.
REQ-018 DONE without start SHALL return to IDLE at the next edge.
REQ-019 DONE with start SHALL go directly to RUN, with done still a single-cycle pulse.
REQ-020 start SHALL be ignored while in RUN: captured operands are not disturbed and latency is not extended.
REQ-021 Changes on A, B or Bin after capture SHALL NOT affect the in-flight result.
REQ-022 Diff and Bout SHALL change only at the edge entering DONE.
REQ-023 Diff and Bout SHALL hold their last result through IDLE and through any following RUN until the next DONE.
REQ-024 The bit index SHALL be ceil(log2(WIDTH)) or more bits wide and SHALL NOT wrap before completion.
REQ-025 The operation SHALL be correct at all boundary values:
- A=0, B=all-ones, Bin=1 gives Diff=0, Bout=1.
- A=all-ones, B=0, Bin=0 gives Diff=all-ones, Bout=0.

Reset
REQ-026 rst_n=0 SHALL, asynchronously and regardless of state, force:
- state to IDLE;
- busy=0, done=0, Diff=0, Bout=0;
- the bit index and internal borrow to 0.
REQ-027 A reset during RUN SHALL abandon the operation with no done pulse and no output update.
REQ-028 After rst_n rises, start SHALL be honoured at the first rising edge at which rst_n is sampled high.

Verification
REQ-029 The bench SHALL cover these directed scenarios, each with WIDTH=4:
- A=0000, B=0000, Bin=0, start pulse -> done 5 cycles later; Diff=0000, Bout=0.
- A=0001, B=0001, Bin=1 -> Diff=1111, Bout=1; busy high exactly 4 cycles.
- A=1010, B=0010, Bin=0 -> Diff=1000, Bout=0. Then A=0010, B=1010, Bin=0 -> Diff=1000, Bout=1.
- start re-pulsed and A changed to 1111 during RUN of 1010-0010 -> result unchanged (1000, 0), single done pulse.
- start held high continuously for 1010-0010 -> back-to-back results, a done pulse every 5 cycles, busy low only in DONE cycles.
- rst_n pulsed low for a partial cycle during RUN -> outputs 0 immediately, no done; a fresh 0111-0011-0 start then yields Diff=0100, Bout=0.
